// File: rtl/instr_encoder.sv
// RV32I field-set to instruction-word encoder that streams encoded words into
// instruction memory at an auto-incrementing write pointer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a field set or a pointer load; ack is ignored
// ST_WRITE | encoded word held on mem_data_w_o until mem_ack_w_i_h
module instr_encoder (
   input  logic        clk_w_i,
   input  logic        rst_w_i_l,
   input  logic        req_valid_w_i_h,
   output logic        req_ready_w_o_h,
   input  logic [6:0]  opcode_w_i,
   input  logic [4:0]  rd_w_i,
   input  logic [4:0]  rs1_w_i,
   input  logic [4:0]  rs2_w_i,
   input  logic [2:0]  funct3_w_i,
   input  logic [6:0]  funct7_w_i,
   input  logic [31:0] imm_w_i,
   input  logic        load_addr_w_i_h,
   input  logic [31:0] base_addr_w_i,
   output logic        mem_wr_w_o_h,
   output logic [31:0] mem_addr_w_o,
   output logic [31:0] mem_data_w_o,
   input  logic        mem_ack_w_i_h,
   output logic        err_w_o_h,
   input  logic        err_clr_w_i_h,
   output logic [15:0] count_w_o
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_AUI  = 7'b0010111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] ptr_q, ptr_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;

   logic [31:0] enc_word;
   logic        op_legal;
   logic        ready;
   logic        set_err;

   always_comb begin
      enc_word = '0;
      op_legal = 1'b1;
      case (opcode_w_i)
         OP_R:
            enc_word = {funct7_w_i, rs2_w_i, rs1_w_i, funct3_w_i, rd_w_i, opcode_w_i};
         OP_IMM, OP_LOAD, OP_JALR:
            enc_word = {imm_w_i[11:0], rs1_w_i, funct3_w_i, rd_w_i, opcode_w_i};
         OP_S:
            enc_word = {imm_w_i[11:5], rs2_w_i, rs1_w_i, funct3_w_i, imm_w_i[4:0], opcode_w_i};
         OP_B:
            enc_word = {imm_w_i[12], imm_w_i[10:5], rs2_w_i, rs1_w_i, funct3_w_i,
                        imm_w_i[4:1], imm_w_i[11], opcode_w_i};
         OP_LUI, OP_AUI:
            enc_word = {imm_w_i[31:12], rd_w_i, opcode_w_i};
         OP_JAL:
            enc_word = {imm_w_i[20], imm_w_i[10:1], imm_w_i[11], imm_w_i[19:12],
                        rd_w_i, opcode_w_i};
         default:
            op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      ready        = 1'b0;
      set_err      = 1'b0;
      mem_wr_w_o_h = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready = ~load_addr_w_i_h;
            if (load_addr_w_i_h) begin
               ptr_d = base_addr_w_i;
            end else if (req_valid_w_i_h) begin
               if (op_legal) begin
                  data_d  = enc_word;
                  state_d = ST_WRITE;
               end else begin
                  set_err = 1'b1;
               end
            end
         end
         ST_WRITE: begin
            mem_wr_w_o_h = 1'b1;
            if (mem_ack_w_i_h) begin
               state_d = ST_IDLE;
               ptr_d   = ptr_q + 32'd4;
               if (cnt_q != 16'hFFFF) begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // a same-cycle illegal acceptance wins over a clear
      if (set_err) begin
         err_d = 1'b1;
      end else if (err_clr_w_i_h) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
      if (!rst_w_i_l) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign req_ready_w_o_h = ready & rst_w_i_l;
   assign mem_addr_w_o    = ptr_q;
   assign mem_data_w_o    = data_q;
   assign err_w_o_h       = err_q;
   assign count_w_o       = cnt_q;

endmodule
